// File: rtl/cpu_pkg.sv
// Shared CPU-core types: id/data/register widths, CDB record and reorder-id wrap helper.
// Used by the reorder commit unit, the load module and the CDB bus adapters.
package cpu_pkg;

  localparam int ID_W        = 3;
  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int NUM_REGS    = 32;
  localparam int ROB_ENTRIES = 7;
  localparam int CNT_W       = $clog2(ROB_ENTRIES + 1);

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_t;

  // Id 0 means "no producer": the register value is already architectural.
  localparam id_t NO_ID = '0;

  typedef struct packed {
    logic  vld;
    id_t   id;
    data_t dat;
  } cdb_t;

  // Ids run 1..ROB_ENTRIES and skip 0 on wrap.
  function automatic id_t next_id(input id_t id);
    return (id == id_t'(ROB_ENTRIES)) ? id_t'(1) : id + id_t'(1);
  endfunction

endpackage

// File: rtl/reorder_commit_unit_rename_table.sv
// Register rename table: producer id per register, r0 never renamed. Updates on the clock
// edge; a same-cycle set beats the commit-time clear, which only fires if the tag still matches.
module rename_table
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [REG_W-1:0]         set_rd,
  input  logic [ID_W-1:0]          set_id,
  input  logic                     clr_en,
  input  logic [REG_W-1:0]         clr_rd,
  input  logic [ID_W-1:0]          clr_id,
  output logic [NUM_REGS*ID_W-1:0] reg_tag
);

  id_t tag_q [1:NUM_REGS-1];
  id_t tag_d [1:NUM_REGS-1];

  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      tag_d[r] = tag_q[r];
      // A younger writer may already own the register; only the current producer may clear it.
      if (clr_en && clr_rd == REG_W'(r) && tag_q[r] == clr_id) tag_d[r] = NO_ID;
      if (set_en && set_rd == REG_W'(r)) tag_d[r] = set_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) tag_q[r] <= NO_ID;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    reg_tag = '0;
    for (int r = 1; r < NUM_REGS; r++) reg_tag[r*ID_W +: ID_W] = tag_q[r];
  end

endmodule

// File: rtl/reorder_commit_unit.sv
// In-order reorder queue: allocates ids 1..7, captures CDB results, retires one entry per cycle.
// Commit is registered (earliest one edge after CDB capture); allocation is refused while full.
module reorder_commit_unit
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [REG_W-1:0]         alloc_rd,
  output logic                     alloc_ready,
  output logic [ID_W-1:0]          alloc_id,
  input  logic                     cdb_valid,
  input  logic [ID_W-1:0]          cdb_id,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic [ID_W-1:0]          lookup_id,
  output logic                     lookup_done,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [NUM_REGS*ID_W-1:0] reg_tag,
  output logic                     commit_valid,
  output logic [ID_W-1:0]          commit_id,
  output logic [REG_W-1:0]         commit_rd,
  output logic [DATA_W-1:0]        commit_data
);

  localparam int SLOTS = 2**ID_W;

  id_t              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SLOTS-1:0] busy_q, busy_d, complete_q, complete_d;
  reg_t             rd_q  [SLOTS];
  reg_t             rd_d  [SLOTS];
  data_t            res_q [SLOTS];
  data_t            res_d [SLOTS];
  logic             commit_valid_q, commit_valid_d;
  id_t              commit_id_q, commit_id_d;
  reg_t             commit_rd_q, commit_rd_d;
  data_t            commit_data_q, commit_data_d;

  cdb_t cdb;
  logic alloc_fire, cdb_fire, commit_fire;

  assign cdb         = '{vld: cdb_valid, id: cdb_id, dat: cdb_data};
  assign alloc_ready = (count_q != CNT_W'(ROB_ENTRIES));
  assign alloc_id    = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cdb_fire    = cdb.vld && cdb.id != NO_ID && busy_q[cdb.id] && !complete_q[cdb.id];
  assign commit_fire = busy_q[head_q] && complete_q[head_q];

  // Tail slot is never busy unless full, and head only commits once complete,
  // so alloc, capture and commit always touch distinct slots.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    complete_d     = complete_q;
    rd_d           = rd_q;
    res_d          = res_q;
    commit_valid_d = commit_fire;
    commit_id_d    = commit_id_q;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;
    if (alloc_fire) begin
      busy_d[tail_q]     = 1'b1;
      complete_d[tail_q] = 1'b0;
      rd_d[tail_q]       = alloc_rd;
      tail_d             = next_id(tail_q);
    end
    if (cdb_fire) begin
      res_d[cdb.id]      = cdb.dat;
      complete_d[cdb.id] = 1'b1;
    end
    if (commit_fire) begin
      commit_id_d    = head_q;
      commit_rd_d    = rd_q[head_q];
      commit_data_d  = res_q[head_q];
      busy_d[head_q] = 1'b0;
      head_d         = next_id(head_q);
    end
    if (alloc_fire && !commit_fire) count_d = count_q + 1'b1;
    if (commit_fire && !alloc_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= id_t'(1);
      tail_q         <= id_t'(1);
      count_q        <= '0;
      busy_q         <= '0;
      complete_q     <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        rd_q[i]  <= '0;
        res_q[i] <= '0;
      end
      commit_valid_q <= 1'b0;
      commit_id_q    <= NO_ID;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      complete_q     <= complete_d;
      rd_q           <= rd_d;
      res_q          <= res_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  // Same-cycle CDB bypass lets issue grab a result before it lands in its slot.
  always_comb begin
    lookup_done = 1'b0;
    lookup_data = '0;
    if (lookup_id != NO_ID) begin
      if (cdb.vld && cdb.id == lookup_id) begin
        lookup_done = 1'b1;
        lookup_data = cdb.dat;
      end else begin
        lookup_done = busy_q[lookup_id] && complete_q[lookup_id];
        lookup_data = res_q[lookup_id];
      end
    end
  end

  rename_table u_rename (
    .clk     (clk),
    .rst     (rst),
    .set_en  (alloc_fire && alloc_rd != '0),
    .set_rd  (alloc_rd),
    .set_id  (tail_q),
    .clr_en  (commit_fire),
    .clr_rd  (rd_q[head_q]),
    .clr_id  (head_q),
    .reg_tag (reg_tag)
  );

  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;

endmodule

// File: doc/reorder_commit_unit.md
Name: reorder_commit_unit

Overview:
- In-order retirement stage downstream of the reservation stations (load module and ALU stations) and the CDB bus adapters.
- Allocates reorder-queue ids 1..7 to issued instructions and owns the register rename table (regState).
- Captures CDB broadcasts into its result slots and retires completed entries strictly in program order to the register file.
- Id 0 is reserved as "no producer / register ready".

Parameters:
- DATA_W, 32, width of the CDB data and result slots
- ID_W, 3, tag width; entries = 2**ID_W - 1 = 7, ids 1..7
- REG_W, 5, register index width; registers 1..31 are renamed, r0 is never renamed

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  issue stage requests an entry
- alloc_rd  in  REG_W  destination register of the issuing instruction (0 = none)
- alloc_ready  out  1  entry available
- alloc_id  out  ID_W  id that will be granted (current tail)
- cdb_valid  in  1  CDB broadcast valid (cdbInt)
- cdb_id  in  ID_W  CDB producer id
- cdb_data  in  DATA_W  CDB result
- lookup_id  in  ID_W  operand tag query from the issue stage
- lookup_done  out  1  tagged result already available
- lookup_data  out  DATA_W  value for lookup_id
- reg_tag  out  32*ID_W  flattened rename table; slice r = producer id of register r; slice 0 is constant 0
- commit_valid  out  1  one-cycle retire pulse
- commit_id  out  ID_W  retired id
- commit_rd  out  REG_W  register file write index (0 = no write)
- commit_data  out  DATA_W  register file write data

Behaviour:
- Reset: head = tail = 1, count = 0, all busy/complete = 0, all reg_tag = 0. commit_valid, commit_id, commit_rd and commit_data are 0. Reset mid-operation discards all in-flight entries immediately.
- Id wrap: next(id) = id==7 ? 1 : id+1. Id 0 is never allocated.
- Allocation:
  - alloc_ready = (count != 7); alloc_id = tail (combinational).
  - On a posedge with alloc_valid && alloc_ready: busy[tail] <= 1, complete[tail] <= 0, rd[tail] <= alloc_rd, tail <= next(tail).
  - If alloc_rd != 0, reg_tag[alloc_rd] <= tail.
  - alloc_ready is computed from the pre-edge count. A full queue refuses allocation even when a commit frees an entry in the same cycle.
- CDB capture:
  - On a posedge with cdb_valid && cdb_id != 0 && busy[cdb_id] && !complete[cdb_id]: res[cdb_id] <= cdb_data, complete[cdb_id] <= 1.
  - Broadcasts to free, already-complete or id-0 entries are ignored with no state change.
- Commit:
  - On a posedge with busy[head] && complete[head]: commit_valid <= 1, commit_id <= head, commit_rd <= rd[head], commit_data <= res[head]; busy[head] <= 0, head <= next(head).
  - Otherwise commit_valid <= 0. At most one retire per cycle.
  - Latency: a CDB write at edge N produces commit_valid high after edge N+1 at the earliest.
- Rename clear:
  - On commit with rd != 0 and reg_tag[rd] == head, reg_tag[rd] <= 0.
  - If an allocation in the same cycle targets the same rd, the allocation wins and reg_tag[rd] <= new tail.
- count: +1 on alloc only, -1 on commit only, unchanged on both.
- Lookup (combinational):
  - If cdb_valid && cdb_id == lookup_id && lookup_id != 0: lookup_done = 1, lookup_data = cdb_data (same-cycle bypass).
  - Else lookup_done = busy[lookup_id] && complete[lookup_id], lookup_data = res[lookup_id].
  - lookup_id == 0 gives lookup_done = 0, lookup_data = 0.
- Mispredict/flush is out of scope; rst is the only flush.

Decomposition:
- Shared package cpu_pkg:
  - ID_W, DATA_W, REG_W
  - NO_ID = 0, ROB_ENTRIES = 7
  - function next_id (1..7 wrap)
  - CDB field widths, shared with the load module and bus adapters
- Sub-module rename_table:
  - Holds the 31 x ID_W regState array.
  - Ports: set (alloc rd/id), clear (commit rd/id with match check, set priority), flattened read.

Test Plan:
- Reset then idle: reg_tag all 0, alloc_ready 1, alloc_id 1, commit_valid never asserts.
- Allocate rd=5 (id 1) and rd=6 (id 2); CDB id 2 data 0xBEEF, then CDB id 1 data 0x1234.
  - Commits are id 1 (rd 5, 0x1234) then id 2 (rd 6, 0xBEEF) on consecutive cycles after the second CDB edge.
  - reg_tag[5] and reg_tag[6] return to 0.
- Allocate 7 entries, then assert alloc_valid again: alloc_ready = 0 and the 8th request is refused. Complete id 1 -> after its commit, alloc_ready = 1 and alloc_id = 1 (wrap).
- Rename overwrite: alloc rd=3 (id 1), alloc rd=3 (id 2), complete and commit id 1 -> reg_tag[3] stays 2. Commit id 2 -> reg_tag[3] = 0.
- Same-cycle clear/set: head id 1 (rd 4) commits in the same cycle as an alloc rd=4 granted id 3 -> reg_tag[4] = 3.
- lookup_id = 2 with CDB id 2 data 0x55 in the same cycle -> lookup_done 1, lookup_data 0x55. Spurious CDB to a free id 6 leaves complete[6] = 0. Assert rst mid-stream -> count 0, commit_valid 0 immediately.
